// File: rtl/lsu_mem_if_pkg.sv
// Shared types, control-encoding constants and the size/alignment rules
// used by the load/store unit and its load extraction block.
package lsu_pkg;

  // Transaction state: accept, issue to memory, wait for ack, respond.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Bit positions inside the decoder's l_choose one-hot.
  localparam int LC_LD  = 0;
  localparam int LC_LW  = 1;
  localparam int LC_LWU = 2;
  localparam int LC_LH  = 3;
  localparam int LC_LHU = 4;
  localparam int LC_LB  = 5;
  localparam int LC_LBU = 6;

  // Store size masks produced by the decoder (right-aligned).
  localparam logic [7:0] WM_B = 8'h01;
  localparam logic [7:0] WM_H = 8'h03;
  localparam logic [7:0] WM_W = 8'h0F;
  localparam logic [7:0] WM_D = 8'hFF;

  // Access size in bytes implied by the control encoding; 0 marks an
  // illegal encoding (unknown store mask, or a load select that is not
  // exactly one-hot).
  function automatic logic [3:0] access_bytes(input logic       wen,
                                              input logic [7:0] wmask,
                                              input logic [6:0] lchoose);
    logic [3:0] n;
    n = 4'd0;
    if (wen) begin
      case (wmask)
        WM_B:    n = 4'd1;
        WM_H:    n = 4'd2;
        WM_W:    n = 4'd4;
        WM_D:    n = 4'd8;
        default: n = 4'd0;
      endcase
    end else if ((lchoose != 7'd0) && ((lchoose & (lchoose - 7'd1)) == 7'd0)) begin
      if (lchoose[LC_LD]) begin
        n = 4'd8;
      end else if (lchoose[LC_LW] | lchoose[LC_LWU]) begin
        n = 4'd4;
      end else if (lchoose[LC_LH] | lchoose[LC_LHU]) begin
        n = 4'd2;
      end else begin
        n = 4'd1;
      end
    end
    return n;
  endfunction

  // A request is legal when its encoding is valid and the byte offset is
  // naturally aligned for the access size.
  function automatic logic access_legal(input logic       wen,
                                        input logic [7:0] wmask,
                                        input logic [6:0] lchoose,
                                        input logic [2:0] off);
    logic ok;
    case (access_bytes(wen, wmask, lchoose))
      4'd1:    ok = 1'b1;
      4'd2:    ok = ~off[0];
      4'd4:    ok = (off[1:0] == 2'd0);
      4'd8:    ok = (off == 3'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Data-memory side bus of the load/store unit: one aligned 64-bit
// valid/ready request channel plus a response/ack strobe with read data.
interface lsu_mem_bus_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [63:0] mem_addr;
  logic        mem_wen;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_rdata;

  // The load/store unit drives requests and consumes responses.
  modport master (
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  // The memory accepts requests and produces responses.
  modport slave (
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wstrb,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );

endinterface

// File: rtl/lsu_mem_if_load_ext.sv
// Load data extraction: shifts the addressed bytes of an aligned 64-bit
// memory word down to bit 0 and sign/zero-extends by load type.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  logic [6:0]  lchoose,
  output logic [63:0] ext
);

  logic [63:0] raw;

  assign raw = rdata >> {off, 3'b000};

  // Select width and extension from the one-hot load type; an all-zero
  // select yields 0 (never reached for accepted legal loads).
  always_comb begin
    ext = 64'd0;
    if (lchoose[LC_LD]) begin
      ext = raw;
    end else if (lchoose[LC_LW]) begin
      ext = {{32{raw[31]}}, raw[31:0]};
    end else if (lchoose[LC_LWU]) begin
      ext = {32'd0, raw[31:0]};
    end else if (lchoose[LC_LH]) begin
      ext = {{48{raw[15]}}, raw[15:0]};
    end else if (lchoose[LC_LHU]) begin
      ext = {48'd0, raw[15:0]};
    end else if (lchoose[LC_LB]) begin
      ext = {{56{raw[7]}}, raw[7:0]};
    end else if (lchoose[LC_LBU]) begin
      ext = {56'd0, raw[7:0]};
    end
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Multi-cycle load/store unit between execute and the data memory port.
// Accepts one request at a time, checks encoding and alignment, issues an
// aligned 64-bit memory transaction, and returns a one-cycle completion.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [63:0]          req_addr,
  input  logic                 req_wen,
  input  logic [63:0]          req_wdata,
  input  logic [7:0]           req_wmask,
  input  logic [6:0]           req_lchoose,
  output logic                 resp_valid,
  output logic [63:0]          resp_rdata,
  output logic                 resp_err,
  lsu_mem_bus_if.master        mem
);

  // Counter value seen in the last WAIT cycle before giving up.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e state_reg;
  lsu_state_e state_next;

  logic [63:0]      addr_reg;
  logic             wen_reg;
  logic [63:0]      wdata_reg;
  logic [7:0]       wmask_reg;
  logic [6:0]       lchoose_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [63:0]      rdata_reg;
  logic             err_reg;

  logic        accept;
  logic        req_legal;
  logic        timeout_hit;
  logic [63:0] load_data;

  assign accept      = req_valid & req_ready;
  assign req_legal   = access_legal(req_wen, req_wmask, req_lchoose, req_addr[2:0]);
  assign timeout_hit = (cnt_reg == TIMEOUT_LAST);

  lsu_load_ext u_load_ext (
    .rdata   (mem.mem_rdata),
    .off     (addr_reg[2:0]),
    .lchoose (lchoose_reg),
    .ext     (load_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state selection; a response in the same cycle as the timeout wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = req_legal ? REQ : RESP;
        end
      end
      REQ: begin
        if (mem.mem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_resp_valid || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture on accept, WAIT cycle counting and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg    <= 64'd0;
      wen_reg     <= 1'b0;
      wdata_reg   <= 64'd0;
      wmask_reg   <= 8'd0;
      lchoose_reg <= 7'd0;
      cnt_reg     <= '0;
      rdata_reg   <= 64'd0;
      err_reg     <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg    <= req_addr;
        wen_reg     <= req_wen;
        wdata_reg   <= req_wdata;
        wmask_reg   <= req_wmask;
        lchoose_reg <= req_lchoose;
        rdata_reg   <= 64'd0;
        err_reg     <= ~req_legal;
      end
      case (state_reg)
        WAIT: begin
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (mem.mem_resp_valid) begin
            rdata_reg <= wen_reg ? 64'd0 : load_data;
            err_reg   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_reg <= 64'd0;
            err_reg   <= 1'b1;
          end
        end
        RESP: begin
          cnt_reg <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Core side: ready only when idle and out of reset; result visible in RESP.
  assign req_ready  = (state_reg == IDLE) & ~rst;
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = (state_reg == RESP) ? rdata_reg : 64'd0;
  assign resp_err   = (state_reg == RESP) ? err_reg : 1'b0;

  // Memory side: fields come straight from the captured request, so they
  // stay stable for as long as the memory holds off ready.
  assign mem.mem_req_valid = (state_reg == REQ);
  assign mem.mem_addr      = (state_reg == REQ) ? {addr_reg[63:3], 3'b000} : 64'd0;
  assign mem.mem_wen       = (state_reg == REQ) ? wen_reg : 1'b0;
  assign mem.mem_wstrb     = (state_reg == REQ) ? (wmask_reg << addr_reg[2:0]) : 8'd0;
  assign mem.mem_wdata     = (state_reg == REQ) ? (wdata_reg << {addr_reg[2:0], 3'b000}) : 64'd0;

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Multi-cycle load/store unit sitting between the NPC decode/execute stage and the data memory port.
- Consumes the decoder's memory-side control encoding:
  - wmask (one of 0x01/0x03/0x0F/0xFF) for stores.
  - l_choose (7-bit one-hot: ld, lw, lwu, lh, lhu, lb, lbu) for loads.
- Issues aligned 64-bit valid/ready transactions to memory.
- Returns the extended load data or a store completion to the core.
- Replaces the combinational data_ram path so memory may take variable latency.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles waited in WAIT before aborting with error (1..65535).
- CNT_W, 16: width of the timeout counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  64  byte address
- req_wen  in  1  1 = store, 0 = load
- req_wdata  in  64  store data, right-aligned (byte 0 = LSB)
- req_wmask  in  8  store size mask from decoder
- req_lchoose  in  7  load type one-hot: bit0 ld, 1 lw, 2 lwu, 3 lh, 4 lhu, 5 lb, 6 lbu
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data (0 for stores and errors)
- resp_err  out  1  misaligned, illegal encoding, or timeout
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  64  req_addr with bits [2:0] cleared
- mem_wen  out  1  memory write
- mem_wdata  out  64  store data shifted to lane
- mem_wstrb  out  8  byte strobes shifted to lane
- mem_resp_valid  in  1  memory response/ack
- mem_rdata  in  64  aligned 64-bit read data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset state: state=IDLE; all outputs 0 except req_ready; timeout counter 0. req_ready=0 while rst=1, and 1 from the first cycle after reset deasserts.
- Reset mid-operation: abandons the transaction with no resp_valid. Memory-side cleanup is the memory's responsibility.
- req_ready is 1 only in IDLE. Accept occurs when req_valid & req_ready; all req_* fields are registered on accept.
- State machine:
  - IDLE: on accept of a legal request go to REQ; on accept of an illegal request go to RESP with err=1.
  - REQ: mem_req_valid=1; mem_addr/wen/wdata/wstrb are stable from registers. Go to WAIT when mem_req_ready=1.
  - WAIT: counter increments every cycle.
    - If mem_resp_valid=1: capture mem_rdata and go to RESP with err=0.
    - Else if counter == TIMEOUT_CYCLES-1: go to RESP with err=1, rdata=0.
    - mem_resp_valid wins over timeout in the same cycle.
  - RESP: resp_valid=1 for exactly one cycle, then back to IDLE; counter is cleared.
- Minimum latency, legal access: accept at cycle 0, REQ at cycle 1; with mem_req_ready=1 and mem_resp_valid in the first WAIT cycle (cycle 2), resp_valid is high at cycle 3.
- Illegal request: resp_valid is high at cycle 1; no memory transaction is issued.
- mem_resp_valid outside WAIT is ignored.
- Legality rules:
  - Store: wmask must be 0x01, 0x03, 0x0F or 0xFF; lchoose is ignored.
  - Load: lchoose must be exactly one-hot; zero or multi-hot is an error.
- Alignment: size 1 any address; size 2 needs addr[0]=0; size 4 needs addr[1:0]=0; size 8 needs addr[2:0]=0. Otherwise the request is an error.
- Store lane placement, with off=addr[2:0]:
  - mem_wstrb = wmask << off, truncated to 8 bits.
  - mem_wdata = wdata << (8*off), truncated to 64 bits.
- Load extraction: raw = mem_rdata >> (8*off). Then:
  - ld: raw
  - lw: sign-extend raw[31:0]; lwu: zero-extend raw[31:0]
  - lh: sign-extend raw[15:0]; lhu: zero-extend raw[15:0]
  - lb: sign-extend raw[7:0]; lbu: zero-extend raw[7:0]
- Stores: resp_rdata=0.
- resp_rdata and resp_err hold their values during RESP and are 0 otherwise.

Decomposition:
- Package lsu_pkg holds:
  - State encoding: IDLE, REQ, WAIT, RESP.
  - l_choose bit indices LC_LD..LC_LBU.
  - Wmask constants WM_B=0x01, WM_H=0x03, WM_W=0x0F, WM_D=0xFF.
  - Size/alignment check function.
- One combinational sub-module, lsu_load_ext: inputs rdata, off, lchoose; output extended 64-bit data. It is unit-testable on its own.

Test Plan:
- Reset, then load lb at addr 0x8000_0003 with mem_rdata=0x0000_0000_8000_0000, ready=1, resp on first WAIT cycle → mem_addr=0x8000_0000; resp_rdata=0xFFFF_FFFF_FFFF_FF80; resp_valid at cycle 3; err=0.
- Store sh, wdata=0x1234, addr 0x106 → mem_addr=0x100, mem_wstrb=0xC0, mem_wdata=0x1234_0000_0000_0000, mem_wen=1; resp_rdata=0.
- mem_req_ready held low 5 cycles → mem_req_valid and all mem_* fields stay stable for 5 cycles, and the request completes after ready rises.
- Misaligned lw at 0x102 → resp_valid=1, err=1 at cycle 1; mem_req_valid never asserts. Repeat with lchoose=0x03 → same error response.
- TIMEOUT_CYCLES=4, mem never responds → resp_err=1, resp_rdata=0 on the 5th cycle after the REQ handshake. A later mem_resp_valid while in IDLE is ignored.
- rst asserted during WAIT → outputs 0 on the next cycle, no resp_valid; a following lwu at 0x4 with rdata=0xFFFF_FFFF_0000_0000 returns 0x0000_0000_FFFF_FFFF.
